sram_ctl: RTL
=============

// Module: sram_ctl
// PURPOSE
//  Registered, handshaked byte-port controller for external asynchronous SRAM.
//  Serves an 8-bit CPU/DMA bus; the SRAM word width is parametrised (8/16/32 bits).
//  Drives glitch-free registered strobes and byte-lane enables; wait states are set at build time.
//  Sits between the bus arbiter and the board SRAM pins.
// PARAMETERS
//  ADDR_W       16  byte address width on the bus side
//  LANE_BITS    1   log2(byte lanes); SRAM_DW = 8<<LANE_BITS, LANES = 1<<LANE_BITS
//  WAIT_STATES  1   extra strobe cycles beyond the first (0..15)
// PORTS
//  clk        in   1                    system clock; all logic on rising edge
//  reset_n    in   1                    asynchronous active-low reset
//  req        in   1                    access request; sampled only while busy=0
//  we         in   1                    1=write, 0=read; sampled with req
//  addr       in   ADDR_W               byte address; sampled with req
//  wdata      in   8                    write byte; sampled with req
//  rdata      out  8                    read byte; valid from ack, held until next read
//  ack        out  1                    one-cycle completion pulse
//  busy       out  1                    1 from the cycle after acceptance until return to IDLE
//  SRAM_ADDR  out  ADDR_W-LANE_BITS     word address = addr[ADDR_W-1:LANE_BITS]
//  SRAM_DQ    inout SRAM_DW             data; only the selected lane is driven, and only on writes
//  SRAM_CE_N  out  1                    chip enable, low for the whole access
//  SRAM_OE_N  out  1                    output enable, low during the read strobe
//  SRAM_WE_N  out  1                    write enable, low during the write strobe
//  SRAM_BE_N  out  LANES                lane enables; bit addr[LANE_BITS-1:0] low, others high
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; busy=0, ack=0, rdata=0.
//    CE_N/OE_N/WE_N=1, BE_N=all 1, SRAM_ADDR=0, DQ all Z; the wait counter clears.
//  - All SRAM pins come from flops; no combinational path from req/addr to pins.
//  - IDLE: when req=1, register addr/we/wdata.
//    Next state is W_SETUP if we=1, else R_STROBE (or TURN, see CONFIGURATION).
//    Accepting a request sets busy=1 in the next cycle.
//  - W_SETUP, 1 cycle: CE_N=0, BE_N=lane, ADDR valid, DQ lane driven, WE_N=1.
//  - W_STROBE, WAIT_STATES+1 cycles: WE_N=0, DQ and ADDR held.
//  - W_HOLD, 1 cycle: WE_N=1, DQ still driven (hold time), ack=1. Next state is IDLE.
//  - R_STROBE, WAIT_STATES+1 cycles: CE_N=0, OE_N=0, BE_N=lane, DQ all Z.
//    On the last cycle, rdata <= SRAM_DQ[lane*8 +: 8].
//  - R_HOLD, 1 cycle: OE_N=1, ack=1, rdata valid. Next state is IDLE.
//  - Latency from the req sample edge to ack high: write = WAIT_STATES+3 cycles, read = WAIT_STATES+2.
//  - Back-to-back: busy=0 only in IDLE, so at least 1 idle cycle separates accesses.
//  - req while busy=1 is ignored, not queued; the master must hold or re-issue req.
//  - The wait counter is 4 bits, reloads on strobe entry, and is decremented to 0; there is no wrap.
//  - Lane select is addr[LANE_BITS-1:0]. With LANE_BITS=0 there is a single lane and BE_N=0 during access.
//  - Unselected DQ lanes are always Z; DQ is never driven when WE_N is not in a write state.
//  - Reset mid-strobe: WE_N/OE_N deassert asynchronously and DQ releases in the same instant; no ack is issued.
// CONFIGURATION
//  SRAM_TURNAROUND_EN defined:
//    - Track the direction of the last access.
//    - A request whose direction differs from the last one first passes through TURN:
//      1 cycle, all strobes high, CE_N=1, DQ Z.
//    - TURN adds +1 cycle to latency for that access only; same-direction accesses are unaffected.
//    - After reset, the last direction is "read".
//  SRAM_TURNAROUND_EN undefined: the TURN state and direction flop are absent; latencies are as above.
// TESTING
//  1. Reset: assert reset_n=0 mid-W_STROBE -> WE_N=1, CE_N=1, DQ=Z, ack=0, busy=0 immediately.
//  2. Write, LANE_BITS=1, W=1: addr=16'h1235, wdata=8'hA5 -> SRAM_ADDR=15'h091A, BE_N=2'b01,
//     DQ[15:8]=A5, DQ[7:0]=Z, WE_N low 2 cycles, ack at req+4.
//  3. Read: SRAM model returns 16'h3C5A at 15'h091A; addr=16'h1234 -> rdata=8'h5A;
//     addr=16'h1235 -> rdata=8'h3C; ack at req+3 each.
//  4. WAIT_STATES=0 and WAIT_STATES=15: write strobe widths are 1 and 16 cycles.
//     ack latencies are 3/18 for writes and 2/17 for reads.
//  5. req pulsed while busy=1 -> no second access and exactly one ack.
//     req held high -> next access starts the cycle after return to IDLE.
//  6. With SRAM_TURNAROUND_EN: write then read -> one cycle with CE_N=1 and DQ=Z before OE_N falls, read ack at req+4.
//     Read then read -> ack at req+3.

Source files
------------

// File: rtl/sram_ctl.sv
// Byte-port controller for an asynchronous SRAM with registered strobes, lane enables and fixed wait states.
// Optional read/write bus turnaround cycle is built when SRAM_TURNAROUND_EN is defined.
module sram_ctl #(
   parameter int ADDR_W      = 16,
   parameter int LANE_BITS   = 1,
   parameter int WAIT_STATES = 1
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          req,
   input  logic                          we,
   input  logic [ADDR_W-1:0]             addr,
   input  logic [7:0]                    wdata,
   output logic [7:0]                    rdata,
   output logic                          ack,
   output logic                          busy,
   output logic [ADDR_W-LANE_BITS-1:0]   SRAM_ADDR,
   inout  wire  [(8<<LANE_BITS)-1:0]     SRAM_DQ,
   output logic                          SRAM_CE_N,
   output logic                          SRAM_OE_N,
   output logic                          SRAM_WE_N,
   output logic [(1<<LANE_BITS)-1:0]     SRAM_BE_N
);

   localparam int LANES = 1 << LANE_BITS;
   localparam int SAW   = ADDR_W - LANE_BITS;

   typedef enum logic [2:0] {
      IDLE,
`ifdef SRAM_TURNAROUND_EN
      TURN,
`endif
      W_SETUP,
      W_STROBE,
      W_HOLD,
      R_STROBE,
      R_HOLD
   } state_t;

   state_t              state_q;
   logic [3:0]          waitCnt_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [7:0]          wdata_q;
   logic [7:0]          rdata_q;
   logic                ack_q;
   logic                busy_q;
   logic [SAW-1:0]      sramAddr_q;
   logic                ceN_q;
   logic                oeN_q;
   logic                weN_q;
   logic [LANES-1:0]    beN_q;
   logic [LANES-1:0]    dqLaneEn_q;
`ifdef SRAM_TURNAROUND_EN
   logic                we_q;
   logic                lastWrite_q;
`endif

   logic [ADDR_W-1:0]   srcAddr_d;
   logic [LANES-1:0]    laneOh_d;
   logic [SAW-1:0]      wordAddr_d;
   logic [ADDR_W-1:0]   laneIdx_d;
   logic [7:0]          rdByte_d;
   logic                goWrite_d;
   logic                goRead_d;
   logic                goTurn_d;

   // Strobe phases start straight from IDLE using the bus inputs, or after TURN from the captured request.
   always_comb begin
      srcAddr_d  = (state_q == IDLE) ? addr : addr_q;
      laneOh_d   = LANES'(1) << (srcAddr_d & ADDR_W'(LANES-1));
      wordAddr_d = srcAddr_d[ADDR_W-1:LANE_BITS];
      laneIdx_d  = addr_q & ADDR_W'(LANES-1);
      rdByte_d   = 8'(SRAM_DQ >> {laneIdx_d, 3'b000});
   end

   always_comb begin
      goWrite_d = 1'b0;
      goRead_d  = 1'b0;
      goTurn_d  = 1'b0;
      if (state_q == IDLE && req) begin
`ifdef SRAM_TURNAROUND_EN
         if (we != lastWrite_q) begin
            goTurn_d = 1'b1;
         end else
`endif
         begin
            goWrite_d = we;
            goRead_d  = !we;
         end
      end
`ifdef SRAM_TURNAROUND_EN
      else if (state_q == TURN) begin
         goWrite_d = we_q;
         goRead_d  = !we_q;
      end
`endif
   end

   // Every pin is a flop so reset releases strobes and the data bus in the same instant.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         waitCnt_q  <= 4'd0;
         addr_q     <= '0;
         wdata_q    <= 8'd0;
         rdata_q    <= 8'd0;
         ack_q      <= 1'b0;
         busy_q     <= 1'b0;
         sramAddr_q <= '0;
         ceN_q      <= 1'b1;
         oeN_q      <= 1'b1;
         weN_q      <= 1'b1;
         beN_q      <= '1;
         dqLaneEn_q <= '0;
`ifdef SRAM_TURNAROUND_EN
         we_q        <= 1'b0;
         lastWrite_q <= 1'b0;
`endif
      end else begin
         ack_q <= 1'b0;
         if (state_q == IDLE && req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            busy_q  <= 1'b1;
`ifdef SRAM_TURNAROUND_EN
            we_q        <= we;
            lastWrite_q <= we;
`endif
         end

         if (goWrite_d) begin
            state_q    <= W_SETUP;
            sramAddr_q <= wordAddr_d;
            ceN_q      <= 1'b0;
            beN_q      <= ~laneOh_d;
            dqLaneEn_q <= laneOh_d;
         end else if (goRead_d) begin
            state_q    <= R_STROBE;
            sramAddr_q <= wordAddr_d;
            ceN_q      <= 1'b0;
            oeN_q      <= 1'b0;
            beN_q      <= ~laneOh_d;
            waitCnt_q  <= 4'(WAIT_STATES);
         end else if (goTurn_d) begin
`ifdef SRAM_TURNAROUND_EN
            state_q <= TURN;
`endif
         end else begin
            case (state_q)
               IDLE: begin
               end
               W_SETUP: begin
                  state_q   <= W_STROBE;
                  weN_q     <= 1'b0;
                  waitCnt_q <= 4'(WAIT_STATES);
               end
               W_STROBE: begin
                  if (waitCnt_q == 4'd0) begin
                     state_q <= W_HOLD;
                     weN_q   <= 1'b1;
                     ack_q   <= 1'b1;
                  end else begin
                     waitCnt_q <= waitCnt_q - 4'd1;
                  end
               end
               R_STROBE: begin
                  if (waitCnt_q == 4'd0) begin
                     state_q <= R_HOLD;
                     oeN_q   <= 1'b1;
                     ack_q   <= 1'b1;
                     rdata_q <= rdByte_d;
                  end else begin
                     waitCnt_q <= waitCnt_q - 4'd1;
                  end
               end
               W_HOLD, R_HOLD: begin
                  state_q    <= IDLE;
                  busy_q     <= 1'b0;
                  ceN_q      <= 1'b1;
                  beN_q      <= '1;
                  dqLaneEn_q <= '0;
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   // Only the selected lane is ever driven; all other lanes stay released.
   for (genvar i = 0; i < LANES; i++) begin : gLane
      assign SRAM_DQ[i*8 +: 8] = dqLaneEn_q[i] ? wdata_q : 8'bz;
   end

   assign rdata     = rdata_q;
   assign ack       = ack_q;
   assign busy      = busy_q;
   assign SRAM_ADDR = sramAddr_q;
   assign SRAM_CE_N = ceN_q;
   assign SRAM_OE_N = oeN_q;
   assign SRAM_WE_N = weN_q;
   assign SRAM_BE_N = beN_q;

endmodule
